// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the scanned seven-segment display.
package seg7_pkg;
    localparam int NDIG = 4;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF = 4'b1111;
    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
endpackage

// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: count/decimal-point inputs and display pin outputs.
interface seg7_scan_display_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;
    modport master (output value, dp_in, input an, seg, dp, frame_start);
    modport slave  (input value, dp_in, output an, seg, dp, frame_start);
endinterface

// File: rtl/seg7_scan_display_hex7seg.sv
// hex7seg: combinational nibble to active-low seven-segment decoder.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_HEX[nib];
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: scans a frame-latched 16-bit value onto a 4-digit common-anode display.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input logic clk,
    input logic rst_n,
    seg7_scan_display_if.slave bus
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic          init;
    logic          tick, load, blank;
    logic [3:0]    nib;
    logic [6:0]    hex;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q, fs_q;

    assign tick  = presc == PW'(REFRESH_DIV - 1);
    assign load  = init || (tick && idx == 2'd3);
    assign nib   = shadow[{idx, 2'b00} +: 4];
    // A digit is a leading zero when it and every more significant nibble are zero
    assign blank = BLANK_LZ && idx != 2'd0 && (shadow >> {idx, 2'b00}) == 16'd0;

    hex7seg u_hex (.nib(nib), .seg(hex));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc  <= '0;
            idx    <= '0;
            shadow <= '0;
            init   <= 1'b1;
            an_q   <= AN_OFF;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
            fs_q   <= 1'b0;
        end else begin
            presc  <= tick ? '0 : presc + PW'(1);
            idx    <= tick ? idx + 2'd1 : idx;
            shadow <= load ? bus.value : shadow;
            init   <= 1'b0;
            an_q   <= blank ? AN_OFF : ~(4'b0001 << idx);
            seg_q  <= blank ? SEG_BLANK : hex;
            dp_q   <= blank | ~bus.dp_in[idx];
            fs_q   <= load;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed plus random checks of two display instances against a cycle-count model.
module tb_seg7_scan_display;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0] dp_in = 4'h0;
    int total = 0;
    int bad = 0;
    int n = 0;
    logic [15:0] m_sh = 16'h0;
    logic [6:0] hex_t [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    seg7_scan_display_if b0 ();
    seg7_scan_display_if b1 ();
    assign b0.value = value;
    assign b0.dp_in = dp_in;
    assign b1.value = value;
    assign b1.dp_in = dp_in;

    seg7_scan_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    seg7_scan_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    function automatic logic [11:0] exp_out(input bit bl, input int k, input logic [15:0] sh, input logic [3:0] dpi);
        logic [3:0] a;
        logic [15:0] hi;
        hi = sh >> (4 * k);
        if (bl && k > 0 && hi == 16'h0) return {4'b1111, 7'b1111111, 1'b1};
        a = 4'b1111;
        a[k] = 1'b0;
        return {a, hex_t[sh[4*k +: 4]], ~dpi[k]};
    endfunction

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s n=%0d got=%b exp=%b", tag, n, got, exp);
        end
    endtask

    // One clock edge: the model predicts from the pre-edge inputs, then outputs are checked #1 later
    task automatic step();
        logic [11:0] e0, e1;
        logic [15:0] v;
        logic ld;
        int k;
        if (!rst_n) begin
            @(posedge clk);
            #1;
            n = 0;
            m_sh = 16'h0;
            chk("rst_out0", {b0.an, b0.seg, b0.dp}, {4'b1111, 7'b1111111, 1'b1});
            chk("rst_out1", {b1.an, b1.seg, b1.dp}, {4'b1111, 7'b1111111, 1'b1});
            chk("rst_fs", {10'd0, b0.frame_start, b1.frame_start}, 12'd0);
        end else begin
            k = (n / 4) % 4;
            ld = (n == 0) || (n % 16 == 15);
            e0 = exp_out(1'b1, k, m_sh, dp_in);
            e1 = exp_out(1'b0, k, m_sh, dp_in);
            v = value;
            @(posedge clk);
            #1;
            if (ld) m_sh = v;
            chk("out_lz", {b0.an, b0.seg, b0.dp}, e0);
            chk("out_nolz", {b1.an, b1.seg, b1.dp}, e1);
            chk("frame_start", {10'd0, b0.frame_start, b1.frame_start}, {10'd0, ld, ld});
            n++;
        end
    endtask

    task automatic run(input int c);
        repeat (c) step();
    endtask

    task automatic do_reset(input int c);
        rst_n = 1'b0;
        run(c);
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        value = 16'h1234;
        do_reset(3);
        run(1);
        chk("first_fs", {11'd0, b0.frame_start}, 12'd1);
        run(1);
        chk("first_digit", {b0.an, b0.seg, b0.dp}, {4'b1110, 7'b0011001, 1'b1});
        value = 16'hA5C3;
        do_reset(1);
        run(34);
        value = 16'h00FF;
        do_reset(1);
        run(22);
        value = 16'hFF00;
        run(30);
        value = 16'h0007;
        do_reset(1);
        run(20);
        value = 16'h0000;
        do_reset(1);
        run(20);
        dp_in = 4'b0100;
        value = 16'h8888;
        do_reset(1);
        run(20);
        dp_in = 4'b0000;
        value = 16'hBEEF;
        do_reset(1);
        run(9);
        do_reset(1);
        run(1);
        chk("restart_fs", {11'd0, b0.frame_start}, 12'd1);
        run(20);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) value = 16'($urandom) >> (4 * $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 60) == 0) do_reset($urandom_range(1, 3));
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
